cache_rr_arbiter: RTL and testbench
===================================

CACHE_RR_ARBITER -- requirements
Module: cache_rr_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of L1 requesters; legal range 2..8.
REQ-002 Parameter ADDR_W, default 32: request address width.
REQ-003 Parameter LINE_W, default 128: cache-line data width.
REQ-004 Parameter PRIO_MODE, default 1: 0 selects fixed priority (lowest index wins); 1 selects round-robin.
REQ-005 Port clk_i, input, 1: the single clock; all state updates on the rising edge.
REQ-006 Port rst_ni, input, 1: reset, synchronous and active-low.
REQ-007 Port req_valid_i, input, NUM_PORTS: per-port request valid; the requester holds it until its resp_ready_o pulse.
REQ-008 Port req_rw_i, input, NUM_PORTS: per-port direction; 1 = write-back, 0 = line fill.
REQ-009 Port req_addr_i, input, NUM_PORTS*ADDR_W: per-port address; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-010 Port req_wdata_i, input, NUM_PORTS*LINE_W: per-port write line, packed the same way as req_addr_i.
REQ-011 Port resp_ready_o, output, NUM_PORTS: one-cycle completion pulse to the granted port.
REQ-012 Port resp_rdata_o, output, LINE_W: read line shared by all ports; valid only while a resp_ready_o bit is high.
REQ-013 Port l2_valid_o, l2_rw_o, l2_addr_o, l2_wdata_o, output, 1/1/ADDR_W/LINE_W: request to the L2.
REQ-014 Port l2_ready_i, input, 1: L2 completion pulse.
REQ-015 Port l2_rdata_i, input, LINE_W: L2 read line; valid while l2_ready_i is high.
REQ-016 Port grant_idx_o, output, 3: index of the current or last granted port.
REQ-017 Port conflict_cnt_o, output, 32: count of arbitration events with more than one requester.

Function
REQ-018 FSM states SHALL be IDLE, BUSY and DONE.
REQ-019 IDLE with any req_valid_i bit high: select a winner, register its rw/addr/wdata and index, and go to BUSY at the next edge.
REQ-020 BUSY: l2_valid_o=1 and the l2_* outputs carry the latched request; later changes on the requester inputs SHALL NOT affect them.
REQ-021 BUSY with l2_ready_i=1: latch l2_rdata_i into resp_rdata_o and go to DONE; l2_valid_o SHALL be 0 from the next cycle.
REQ-022 DONE lasts exactly 1 cycle: resp_ready_o[grant]=1, all other bits 0; then return to IDLE.
REQ-023 Latency: request in IDLE at cycle 0 -> l2_valid_o=1 in cycle 1; l2_ready_i in cycle k -> resp_ready_o pulse in cycle k+1.
REQ-024 In IDLE, l2_valid_o SHALL be 0; the first arbitration can therefore happen one cycle after DONE, by which time the served requester has dropped req_valid_i.
REQ-025 Fixed-priority mode: the lowest-indexed valid port wins.
REQ-026 Round-robin mode: search starts at (last_grant+1) mod NUM_PORTS and wraps past NUM_PORTS-1 to 0; last_grant updates on entry to BUSY.
REQ-027 conflict_cnt_o SHALL increment by 1 on each IDLE->BUSY transition where popcount(req_valid_i)>1, and saturate at 0xFFFFFFFF.
REQ-028 Writes SHALL complete through the same handshake; resp_rdata_o then holds the sampled l2_rdata_i, and ports ignore it.
REQ-029 A req_valid_i deasserted during BUSY (protocol violation) SHALL NOT abort the transaction; the response is still pulsed.
REQ-030 l2_ready_i outside BUSY SHALL be ignored.

Reset
REQ-031 rst_ni=0 at a clock edge: FSM=IDLE, l2_valid_o=0, resp_ready_o=0, resp_rdata_o=0, l2_rw_o/addr/wdata=0, grant_idx_o=0, last_grant=NUM_PORTS-1 (port 0 wins first in round-robin), conflict_cnt_o=0.
REQ-032 Reset during BUSY or DONE abandons the transaction: no resp_ready_o pulse, and l2_valid_o=0 from the cycle after the reset edge.

Verification
REQ-033 Single request: port 1 read at addr 0x0000_0040; L2 ready 3 cycles later with line 0xA5...A5 -> l2_valid_o high for cycles 1-3, resp_ready_o=2'b10 in cycle 4, resp_rdata_o=0xA5...A5.
REQ-034 Round-robin contention: NUM_PORTS=4, all ports continuously requesting -> grant order 0,1,2,3,0; conflict_cnt_o=4 after the first four grants.
REQ-035 Fixed mode: ports 0 and 2 continuously requesting -> port 0 granted every time; port 2 granted only once port 0 stops requesting.
REQ-036 Input change in BUSY: port 0 addr changes 0x100->0x200 after the grant -> l2_addr_o stays 0x100 until DONE.
REQ-037 Reset mid-BUSY, then L2 ready -> no resp_ready_o pulse, l2_valid_o=0, conflict_cnt_o=0, and port 0 wins next.
REQ-038 Saturation: force conflict_cnt_o to 0xFFFFFFFF, then one more contended grant -> conflict_cnt_o stays 0xFFFFFFFF.

Source files
------------

// File: rtl/cache_rr_arbiter.sv
// Arbitrates NUM_PORTS L1 line requests onto a single L2 port, one transaction at a time.
// Fixed-priority or round-robin selection; the granted request is latched for the whole L2 handshake.
module cache_rr_arbiter #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 32,
   parameter int LINE_W    = 128,
   parameter int PRIO_MODE = 1
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [NUM_PORTS-1:0]        req_valid_i,
   input  logic [NUM_PORTS-1:0]        req_rw_i,
   input  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_PORTS*LINE_W-1:0] req_wdata_i,
   output logic [NUM_PORTS-1:0]        resp_ready_o,
   output logic [LINE_W-1:0]           resp_rdata_o,
   output logic                        l2_valid_o,
   output logic                        l2_rw_o,
   output logic [ADDR_W-1:0]           l2_addr_o,
   output logic [LINE_W-1:0]           l2_wdata_o,
   input  logic                        l2_ready_i,
   input  logic [LINE_W-1:0]           l2_rdata_i,
   output logic [2:0]                  grant_idx_o,
   output logic [31:0]                 conflict_cnt_o
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e              state_q, state_d;
   logic [2:0]          grant_q, last_q, win;
   logic                found, contended;
   logic [7:0]          req_pad;
   logic [3:0]          base, cand;
   logic                sel_rw;
   logic [ADDR_W-1:0]   sel_addr;
   logic [LINE_W-1:0]   sel_wdata;
   logic                rw_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [LINE_W-1:0]   wdata_q, rdata_q;
   logic [31:0]         conflict_cnt_q;

   assign req_pad   = 8'(req_valid_i);
   assign contended = |(req_valid_i & (req_valid_i - NUM_PORTS'(1)));

   // Search starts after the last grant in round-robin mode, at port 0 in fixed mode.
   always_comb begin
      win   = '0;
      found = 1'b0;
      base  = '0;
      cand  = '0;
      if (PRIO_MODE != 0)
         base = (4'(last_q) + 4'd1 >= 4'(NUM_PORTS)) ? 4'd0 : 4'(last_q) + 4'd1;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand = base + 4'(i);
         if (cand >= 4'(NUM_PORTS))
            cand = cand - 4'(NUM_PORTS);
         if (!found && req_pad[cand[2:0]]) begin
            found = 1'b1;
            win   = cand[2:0];
         end
      end
   end

   always_comb begin
      sel_rw    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (win == 3'(i)) begin
            sel_rw    = req_rw_i[i];
            sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata_i[i*LINE_W +: LINE_W];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (found) state_d = BUSY;
         BUSY:    if (l2_ready_i) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // last_q resets to the top port so port 0 is searched first.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         grant_q <= '0;
         last_q  <= 3'(NUM_PORTS - 1);
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (state_q == IDLE && found) begin
            grant_q <= win;
            last_q  <= win;
            rw_q    <= sel_rw;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
         end
         if (state_q == BUSY && l2_ready_i)
            rdata_q <= l2_rdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni)
         conflict_cnt_q <= '0;
      else if (state_q == IDLE && found && contended && conflict_cnt_q != 32'hFFFF_FFFF)
         conflict_cnt_q <= conflict_cnt_q + 32'd1;
   end

   assign l2_valid_o     = (state_q == BUSY);
   assign l2_rw_o        = rw_q;
   assign l2_addr_o      = addr_q;
   assign l2_wdata_o     = wdata_q;
   assign resp_ready_o   = (state_q == DONE) ? (NUM_PORTS'(1) << grant_q) : '0;
   assign resp_rdata_o   = rdata_q;
   assign grant_idx_o    = grant_q;
   assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_cache_rr_arbiter.sv
// Bench for cache_rr_arbiter: vector table, directed corner sequences and a
// randomized run checked against a transaction-level arbitration model.
module tb_cache_rr_arbiter;
   localparam int NP = 4;
   localparam int AW = 32;
   localparam int LW = 128;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic [NP-1:0]    req_valid = '0, req_rw = '0;
   logic [NP*AW-1:0] req_addr = '0;
   logic [NP*LW-1:0] req_wdata = '0;
   logic             l2_ready = 1'b0;
   logic [LW-1:0]    l2_rdata = '0;

   logic [NP-1:0] resp_ready, fx_resp_ready;
   logic [LW-1:0] resp_rdata, fx_resp_rdata, l2_wdata, fx_l2_wdata;
   logic          l2_valid, fx_l2_valid, l2_rw, fx_l2_rw;
   logic [AW-1:0] l2_addr, fx_l2_addr;
   logic [2:0]    grant_idx, fx_grant_idx;
   logic [31:0]   conflict_cnt, fx_conflict_cnt;

   cache_rr_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .LINE_W(LW), .PRIO_MODE(1)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_rw_i(req_rw),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .resp_ready_o(resp_ready),
      .resp_rdata_o(resp_rdata), .l2_valid_o(l2_valid), .l2_rw_o(l2_rw),
      .l2_addr_o(l2_addr), .l2_wdata_o(l2_wdata), .l2_ready_i(l2_ready),
      .l2_rdata_i(l2_rdata), .grant_idx_o(grant_idx), .conflict_cnt_o(conflict_cnt));

   cache_rr_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .LINE_W(LW), .PRIO_MODE(0)) dut_fx (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_rw_i(req_rw),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .resp_ready_o(fx_resp_ready),
      .resp_rdata_o(fx_resp_rdata), .l2_valid_o(fx_l2_valid), .l2_rw_o(fx_l2_rw),
      .l2_addr_o(fx_l2_addr), .l2_wdata_o(fx_l2_wdata), .l2_ready_i(l2_ready),
      .l2_rdata_i(l2_rdata), .grant_idx_o(fx_grant_idx), .conflict_cnt_o(fx_conflict_cnt));

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   logic [AW-1:0] addr_m [NP];
   logic          rw_m   [NP];
   logic [LW-1:0] wd_m   [NP];
   int            last_m;
   logic [31:0]   cnt_m;

   typedef struct {
      logic [NP-1:0] req;
      int            exp_w;
      logic [31:0]   exp_cnt;
   } vec_t;
   vec_t tbl [10];

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive();
      for (int p = 0; p < NP; p++) begin
         req_rw[p]              = rw_m[p];
         req_addr[p*AW +: AW]   = addr_m[p];
         req_wdata[p*LW +: LW]  = wd_m[p];
      end
   endtask

   task automatic do_reset();
      rst_ni    = 1'b0;
      req_valid = '0;
      l2_ready  = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      last_m = NP - 1;
      cnt_m  = '0;
   endtask

   function automatic int rr_pick(input logic [NP-1:0] r, input int last);
      for (int k = 1; k <= NP; k++)
         if (r[(last + k) % NP]) return (last + k) % NP;
      return -1;
   endfunction

   // One full transaction on the round-robin DUT: caller has set req_valid in an IDLE cycle.
   task automatic txn(input string tag, input int w, input int lat, input logic [LW-1:0] line);
      logic [NP-1:0] one;
      tick();
      chk({tag, ".l2_valid"}, LW'(l2_valid), LW'(1));
      chk({tag, ".grant"}, LW'(grant_idx), LW'(w));
      chk({tag, ".l2_addr"}, LW'(l2_addr), LW'(addr_m[w]));
      chk({tag, ".l2_rw"}, LW'(l2_rw), LW'(rw_m[w]));
      chk({tag, ".l2_wdata"}, l2_wdata, wd_m[w]);
      for (int p = 0; p < NP; p++) begin
         req_addr[p*AW +: AW]  = ~addr_m[p];
         req_wdata[p*LW +: LW] = ~wd_m[p];
      end
      req_rw = ~req_rw;
      repeat (lat) begin
         tick();
         chk({tag, ".hold_valid"}, LW'(l2_valid), LW'(1));
         chk({tag, ".hold_addr"}, LW'(l2_addr), LW'(addr_m[w]));
         chk({tag, ".no_resp"}, LW'(resp_ready), '0);
      end
      l2_ready = 1'b1;
      l2_rdata = line;
      tick();
      l2_ready = 1'b0;
      l2_rdata = '0;
      one = NP'(1) << w;
      chk({tag, ".resp"}, LW'(resp_ready), LW'(one));
      chk({tag, ".rdata"}, resp_rdata, line);
      chk({tag, ".l2_drop"}, LW'(l2_valid), '0);
      req_valid[w] = 1'b0;
      drive();
      tick();
      chk({tag, ".resp_end"}, LW'(resp_ready), '0);
   endtask

   initial begin
      logic [NP-1:0] pend;
      int w;

      tbl[0] = '{4'b1111, 0, 32'd1};
      tbl[1] = '{4'b1111, 1, 32'd2};
      tbl[2] = '{4'b1111, 2, 32'd3};
      tbl[3] = '{4'b1111, 3, 32'd4};
      tbl[4] = '{4'b1111, 0, 32'd5};
      tbl[5] = '{4'b0001, 0, 32'd5};
      tbl[6] = '{4'b1000, 3, 32'd5};
      tbl[7] = '{4'b0110, 1, 32'd6};
      tbl[8] = '{4'b0101, 2, 32'd7};
      tbl[9] = '{4'b0011, 0, 32'd8};
      for (int p = 0; p < NP; p++) begin
         addr_m[p] = 32'h1000 + 32'(p) * 32'h40;
         rw_m[p]   = 1'(p);
         wd_m[p]   = {4{32'hC0DE_0000 | 32'(p)}};
      end
      drive();

      do_reset();
      chk("rst.l2_valid", LW'(l2_valid), '0);
      chk("rst.resp", LW'(resp_ready), '0);
      chk("rst.rdata", resp_rdata, '0);
      chk("rst.l2_addr", LW'(l2_addr), '0);
      chk("rst.l2_wdata", l2_wdata, '0);
      chk("rst.grant", LW'(grant_idx), '0);
      chk("rst.cnt", LW'(conflict_cnt), '0);
      chk("rst.fx_l2_valid", LW'(fx_l2_valid), '0);

      // Single read from port 1, L2 answers in cycle 3.
      addr_m[1] = 32'h0000_0040; rw_m[1] = 1'b0; drive();
      req_valid = 4'b0010;
      tick();
      chk("single.c1_valid", LW'(l2_valid), LW'(1));
      chk("single.addr", LW'(l2_addr), LW'(32'h40));
      tick();
      chk("single.c2_valid", LW'(l2_valid), LW'(1));
      tick();
      chk("single.c3_valid", LW'(l2_valid), LW'(1));
      l2_ready = 1'b1; l2_rdata = {16{8'hA5}};
      tick();
      l2_ready = 1'b0; l2_rdata = '0;
      chk("single.resp", LW'(resp_ready), LW'(4'b0010));
      chk("single.rdata", resp_rdata, {16{8'hA5}});
      chk("single.c4_valid", LW'(l2_valid), '0);
      req_valid = '0;
      tick();
      chk("single.resp_end", LW'(resp_ready), '0);

      do_reset();
      addr_m[1] = 32'h1040; rw_m[1] = 1'b1; drive();
      for (int i = 0; i < 10; i++) begin
         req_valid = tbl[i].req;
         txn($sformatf("tbl%0d", i), tbl[i].exp_w, i % 3, {4{32'h1111_0000 + 32'(i)}});
         chk($sformatf("tbl%0d.cnt", i), LW'(conflict_cnt), LW'(tbl[i].exp_cnt));
      end

      // Requester address changes while BUSY.
      addr_m[0] = 32'h100; drive();
      req_valid = 4'b0001;
      tick();
      chk("hold.addr0", LW'(l2_addr), LW'(32'h100));
      req_addr[0 +: AW] = 32'h200;
      tick();
      chk("hold.addr1", LW'(l2_addr), LW'(32'h100));
      l2_ready = 1'b1;
      tick();
      l2_ready = 1'b0;
      chk("hold.resp", LW'(resp_ready), LW'(4'b0001));
      chk("hold.addr_done", LW'(l2_addr), LW'(32'h100));
      req_valid = '0; drive();
      tick();

      // Requester drops valid mid-transaction; response still pulses.
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      l2_ready = 1'b1;
      tick();
      l2_ready = 1'b0;
      chk("drop.resp", LW'(resp_ready), LW'(4'b1000));
      tick();

      // Fixed priority: ports 0 and 2 keep requesting.
      do_reset();
      for (int n = 0; n < 3; n++) begin
         req_valid = 4'b0101;
         tick();
         chk($sformatf("fx%0d.grant", n), LW'(fx_grant_idx), '0);
         chk($sformatf("fx%0d.addr", n), LW'(fx_l2_addr), LW'(addr_m[0]));
         l2_ready = 1'b1;
         tick();
         l2_ready = 1'b0;
         chk($sformatf("fx%0d.resp", n), LW'(fx_resp_ready), LW'(4'b0001));
         req_valid[0] = 1'b0;
         tick();
      end
      req_valid = 4'b0100;
      tick();
      chk("fx3.grant", LW'(fx_grant_idx), LW'(2));
      l2_ready = 1'b1;
      tick();
      l2_ready = 1'b0;
      chk("fx3.resp", LW'(fx_resp_ready), LW'(4'b0100));
      chk("fx.cnt", LW'(fx_conflict_cnt), LW'(3));
      req_valid = '0;
      tick();

      // Reset while BUSY, then a stray L2 ready.
      do_reset();
      req_valid = 4'b0100;
      tick();
      chk("rbusy.valid", LW'(l2_valid), LW'(1));
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      req_valid = '0;
      l2_ready = 1'b1;
      chk("rbusy.l2_valid0", LW'(l2_valid), '0);
      tick();
      l2_ready = 1'b0;
      chk("rbusy.resp", LW'(resp_ready), '0);
      chk("rbusy.l2_valid1", LW'(l2_valid), '0);
      chk("rbusy.cnt", LW'(conflict_cnt), '0);
      last_m = NP - 1; cnt_m = '0;
      req_valid = 4'b0101;
      w = rr_pick(4'b0101, last_m);
      last_m = w; cnt_m++;
      txn("rbusy.next", w, 1, {4{32'hFACE_0001}});
      chk("rbusy.next_grant0", LW'(w), '0);
      chk("rbusy.next_cnt", LW'(conflict_cnt), LW'(cnt_m));

      // Randomized traffic against the reference model.
      do_reset();
      pend = '0;
      for (int it = 0; it < 200; it++) begin
         for (int p = 0; p < NP; p++) begin
            if (!pend[p] && $urandom_range(0, 2) == 0) begin
               pend[p]   = 1'b1;
               addr_m[p] = $urandom;
               rw_m[p]   = 1'($urandom);
               wd_m[p]   = {$urandom, $urandom, $urandom, $urandom};
            end
         end
         req_valid = pend;
         drive();
         if (pend == '0) begin
            l2_ready = 1'($urandom);
            l2_rdata = {$urandom, $urandom, $urandom, $urandom};
            tick();
            l2_ready = 1'b0;
            chk("rnd.idle_valid", LW'(l2_valid), '0);
            chk("rnd.idle_resp", LW'(resp_ready), '0);
         end else begin
            w = rr_pick(pend, last_m);
            if ($countones(pend) > 1 && cnt_m != 32'hFFFF_FFFF) cnt_m++;
            last_m = w;
            txn($sformatf("rnd%0d", it), w, int'($urandom_range(0, 3)),
                {$urandom, $urandom, $urandom, $urandom});
            pend[w] = 1'b0;
            chk("rnd.cnt", LW'(conflict_cnt), LW'(cnt_m));
         end
      end

      // Counter saturation.
      req_valid = '0;
      tick();
      force dut.conflict_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.conflict_cnt_q;
      req_valid = 4'b1111;
      drive();
      w = rr_pick(4'b1111, last_m);
      last_m = w;
      txn("sat", w, 0, {4{32'h5A5A_5A5A}});
      chk("sat.cnt", LW'(conflict_cnt), LW'(32'hFFFF_FFFF));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
